pc_sequencer: RTL

Controller for the fetch-stage program-counter register: computes the next PC every cycle and decides when the PC holds, redirects or halts. It arbitrates between instruction-memory wait, EX-stage branch/jump redirect, decode load-use hazard and halt. It drives the PC register's `i_pc`/`i_pc_stall` and the IF/ID and ID/EX stall/flush controls. PC correctness never depends on the register's stall input: whenever the PC must hold, `o_next_pc` equals `i_pc`.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_sequencer_sat_counter.sv | 26 ++
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Holds the FSM state encoding, the default PC increment and the stall/flush control bundle.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } state_e;

   localparam logic [31:0] PC_STEP_DEF = 32'd4;

   typedef struct packed {
      logic pc_stall;
      logic ifid_stall;
      logic ifid_flush;
      logic idex_flush;
   } pc_ctrl_t;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] cnt_r;

   // count enabled cycles until the all-ones ceiling
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_r <= {W{1'b0}};
      end else if (i_en && (cnt_r != {W{1'b1}})) begin
         cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign o_cnt = cnt_r;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: picks the next PC and the pipeline stall/flush controls each cycle.
// Whenever the PC must hold, o_next_pc is driven with i_pc so the PC register's stall input is optional.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] PC_STEP = PC_STEP_DEF,
   parameter int          CNT_W   = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [31:0]      i_pc,
   input  logic             i_imem_ready,
   input  logic             i_br_taken,
   input  logic [31:0]      i_br_target,
   input  logic             i_ld_use,
   input  logic             i_halt,
   output logic [31:0]      o_next_pc,
   output logic             o_pc_stall,
   output logic             o_ifid_stall,
   output logic             o_ifid_flush,
   output logic             o_idex_flush,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_cnt
);

   state_e      state_r, state_s;
   logic        pend_r, pend_s;
   logic [31:0] pend_tgt_r, pend_tgt_s;
   logic [31:0] next_pc_s;
   pc_ctrl_t    ctrl_s;

   // state, pending flag and pending target registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r    <= RUN;
         pend_r     <= 1'b0;
         pend_tgt_r <= 32'd0;
      end else begin
         state_r    <= state_s;
         pend_r     <= pend_s;
         pend_tgt_r <= pend_tgt_s;
      end
   end

   // next-PC priority resolution and next-state logic
   always_comb begin
      state_s    = state_r;
      pend_s     = pend_r;
      pend_tgt_s = pend_tgt_r;
      next_pc_s  = i_pc + PC_STEP;
      ctrl_s     = '{pc_stall: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0};
      case (state_r)
         RUN, WAIT: begin
            if ((state_r == WAIT) && !i_imem_ready) begin
               // still waiting: only the first redirect seen is kept
               next_pc_s         = i_pc;
               ctrl_s.pc_stall   = 1'b1;
               ctrl_s.ifid_flush = 1'b1;
               if (i_br_taken && !pend_r) begin
                  pend_s     = 1'b1;
                  pend_tgt_s = i_br_target;
               end else begin
                  pend_s     = pend_r;
                  pend_tgt_s = pend_tgt_r;
               end
            end else if (pend_r) begin
               next_pc_s         = pend_tgt_r;
               ctrl_s.ifid_flush = 1'b1;
               pend_s            = 1'b0;
               state_s           = RUN;
            end else if (i_br_taken) begin
               ctrl_s.ifid_flush = 1'b1;
               ctrl_s.idex_flush = 1'b1;
               if (i_imem_ready) begin
                  next_pc_s = i_br_target;
                  state_s   = RUN;
               end else begin
                  // fetch in flight: remember the target and apply it once memory answers
                  next_pc_s       = i_pc;
                  ctrl_s.pc_stall = 1'b1;
                  pend_s          = 1'b1;
                  pend_tgt_s      = i_br_target;
                  state_s         = WAIT;
               end
            end else if (i_halt) begin
               next_pc_s         = i_pc;
               ctrl_s.pc_stall   = 1'b1;
               ctrl_s.ifid_flush = 1'b1;
               ctrl_s.idex_flush = 1'b1;
               state_s           = HALT;
            end else if (!i_imem_ready) begin
               next_pc_s         = i_pc;
               ctrl_s.pc_stall   = 1'b1;
               ctrl_s.ifid_flush = 1'b1;
               state_s           = WAIT;
            end else if (i_ld_use) begin
               next_pc_s         = i_pc;
               ctrl_s.pc_stall   = 1'b1;
               ctrl_s.ifid_stall = 1'b1;
               ctrl_s.idex_flush = 1'b1;
               state_s           = RUN;
            end else begin
               next_pc_s = i_pc + PC_STEP;
               state_s   = RUN;
            end
         end
         HALT: begin
            next_pc_s         = i_pc;
            ctrl_s.pc_stall   = 1'b1;
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
            state_s           = HALT;
         end
         default: begin
            next_pc_s         = i_pc;
            ctrl_s.pc_stall   = 1'b1;
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
            pend_s            = 1'b0;
            state_s           = RUN;
         end
      endcase
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (ctrl_s.pc_stall),
      .o_cnt (o_stall_cnt)
   );

   assign o_next_pc    = next_pc_s;
   assign o_pc_stall   = ctrl_s.pc_stall;
   assign o_ifid_stall = ctrl_s.ifid_stall;
   assign o_ifid_flush = ctrl_s.ifid_flush;
   assign o_idex_flush = ctrl_s.idex_flush;
   assign o_state      = state_r;

endmodule
